// File: rtl/la_clbcfg4p0.sv
// Bitstream loader for an N x BLE4P0 CLB: assembles W-bit words into a shadow
// image and commits it atomically to double-buffered config outputs.
module la_clbcfg4p0 #(
  parameter int N = 2,
  parameter int I = 8,
  parameter int K = 4,
  parameter int W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [W-1:0]                in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [N*16-1:0]             cfglut,
  output logic [N-1:0]                cfgbp,
  output logic [N*K*$clog2(I)-1:0]    cfgin,
  output logic [N*K*$clog2(N)-1:0]    cfgfb,
  output logic [N*K-1:0]              cfgloc
);

  localparam int LW   = N * 16;
  localparam int BW   = N;
  localparam int IW   = N * K * $clog2(I);
  localparam int FW   = N * K * $clog2(N);
  localparam int SW   = N * K;
  localparam int CFGW = LW + BW + IW + FW + SW;
  localparam int NW   = (CFGW + W - 1) / W;
  localparam int SHW  = NW * W;
  localparam int CW   = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, COMMIT, DONE, ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SHW-1:0]  shadow_q, shadow_d;
  logic [CFGW-1:0] cfg_q, cfg_d;
  logic            pad_ok;

  // Shadow bits past the image are padding and must arrive as zero.
  if (SHW > CFGW) begin : g_pad
    assign pad_ok = ~|shadow_q[SHW-1:CFGW];
  end else begin : g_nopad
    assign pad_ok = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        if (start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (in_valid) begin
          shadow_d[cnt_q*W +: W] = in_data;
          if (cnt_q == LAST) state_d = COMMIT;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        if (pad_ok) begin
          cfg_d   = shadow_q[CFGW-1:0];
          state_d = DONE;
        end else begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD) || (state_q == COMMIT);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);

  assign cfglut = cfg_q[0 +: LW];
  assign cfgbp  = cfg_q[LW +: BW];
  assign cfgin  = cfg_q[LW+BW +: IW];
  assign cfgfb  = cfg_q[LW+BW+IW +: FW];
  assign cfgloc = cfg_q[LW+BW+IW+FW +: SW];

endmodule
